// File: rtl/cpu_pkg.sv
// Shared encodings for the 16-bit multi-cycle core control path.
// Opcodes, ALU ops, sequencer states, instruction fields and decode bundle.
package cpu_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_ADD   = 4'h1,
        OP_SUB   = 4'h2,
        OP_AND   = 4'h3,
        OP_OR    = 4'h4,
        OP_XOR   = 4'h5,
        OP_SHL   = 4'h6,
        OP_SHR   = 4'h7,
        OP_ADDI  = 4'h8,
        OP_LDI   = 4'h9,
        OP_JMP   = 4'hA,
        OP_BEQZ  = 4'hB,
        OP_RSV_C = 4'hC,
        OP_RSV_D = 4'hD,
        OP_RSV_E = 4'hE,
        OP_HALT  = 4'hF
    } opcode_t;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_SUB   = 3'b001,
        ALU_AND   = 3'b010,
        ALU_OR    = 3'b011,
        ALU_XOR   = 3'b100,
        ALU_SHL   = 3'b101,
        ALU_SHR   = 3'b110,
        ALU_PASSB = 3'b111
    } alu_op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_HALT
    } state_t;

    localparam int OP_HI   = 15;
    localparam int OP_LO   = 12;
    localparam int RD_HI   = 11;
    localparam int RD_LO   = 9;
    localparam int RS1_HI  = 8;
    localparam int RS1_LO  = 6;
    localparam int RS2_HI  = 5;
    localparam int RS2_LO  = 3;
    localparam int IMM6_HI = 5;
    localparam int IMM6_LO = 0;
    localparam int IMM8_HI = 7;
    localparam int IMM8_LO = 0;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       mux1_sel;
        logic       mux2_sel;
        logic       writes_rf;
        logic       is_jmp;
        logic       is_beqz;
        logic       is_halt;
        logic       is_illegal;
    } ctrl_t;

endpackage

// File: rtl/cpu_decoder.sv
// Combinational opcode decode into the datapath control bundle.
// Reserved opcodes C..E behave as NOP and raise is_illegal.
module cpu_decoder
    import cpu_pkg::*;
(
    input  logic [3:0] opcode,
    output ctrl_t      ctrl
);

    logic is_rtype;
    logic is_rsv;

    assign is_rtype = (opcode >= 4'(OP_ADD)) && (opcode <= 4'(OP_SHR));
    assign is_rsv   = (opcode >= 4'(OP_RSV_C)) && (opcode <= 4'(OP_RSV_E));

    always_comb begin
        ctrl = '0;
        unique case (1'b1)
            is_rtype: begin
                ctrl.alu_op    = opcode[2:0] - 3'd1;
                ctrl.writes_rf = 1'b1;
            end
            (opcode == OP_ADDI): begin
                ctrl.alu_op    = ALU_ADD;
                ctrl.mux1_sel  = 1'b1;
                ctrl.writes_rf = 1'b1;
            end
            (opcode == OP_LDI): begin
                ctrl.mux2_sel  = 1'b1;
                ctrl.writes_rf = 1'b1;
            end
            (opcode == OP_JMP):  ctrl.is_jmp     = 1'b1;
            (opcode == OP_BEQZ): ctrl.is_beqz    = 1'b1;
            (opcode == OP_HALT): ctrl.is_halt    = 1'b1;
            is_rsv:              ctrl.is_illegal = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer: owns pc/ir, fetches over req/ack,
// and drives ALU op, mux selects and register-file write per state.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter int              INSTR_W  = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               run,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               src_zero,
    output logic [PC_W-1:0]    pc,
    output logic [INSTR_W-1:0] ir,
    output logic [2:0]         rf_raddr_a,
    output logic [2:0]         rf_raddr_b,
    output logic [2:0]         rf_waddr,
    output logic               rf_we,
    output logic [2:0]         alu_op,
    output logic               mux1_sel,
    output logic               mux2_sel,
    output logic               halted,
    output logic               illegal,
    output logic [15:0]        retired
);

    state_t          state_q;
    state_t          state_d;
    ctrl_t           ctrl;
    logic            branch_taken;
    logic [PC_W-1:0] target;
    logic            ctl_valid;

    cpu_decoder u_dec (
        .opcode (ir[OP_HI:OP_LO]),
        .ctrl   (ctrl)
    );

    assign target = PC_W'(ir[IMM8_HI:IMM8_LO]);

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Outputs decode only registered state and ir, so they hold per state.
    always_comb begin
        state_d    = state_q;
        imem_req   = 1'b0;
        imem_addr  = pc;
        rf_raddr_a = ir[RS1_HI:RS1_LO];
        rf_raddr_b = ir[RS2_HI:RS2_LO];
        rf_waddr   = ir[RD_HI:RD_LO];
        rf_we      = 1'b0;
        alu_op     = ALU_ADD;
        mux1_sel   = 1'b0;
        mux2_sel   = 1'b0;
        halted     = 1'b0;
        illegal    = 1'b0;
        ctl_valid  = (state_q == S_EXECUTE) || (state_q == S_WRITEBACK);

        if (ctrl.is_beqz) rf_raddr_a = ir[RD_HI:RD_LO];

        if (ctl_valid) begin
            alu_op   = ctrl.alu_op;
            mux1_sel = ctrl.mux1_sel;
            mux2_sel = ctrl.mux2_sel;
        end

        unique case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) state_d = S_DECODE;
            end
            S_DECODE: state_d = S_EXECUTE;
            S_EXECUTE: begin
                illegal = ctrl.is_illegal;
                state_d = ctrl.is_halt ? S_HALT : S_WRITEBACK;
            end
            S_WRITEBACK: begin
                rf_we   = ctrl.writes_rf;
                state_d = run ? S_FETCH : S_IDLE;
            end
            S_HALT: halted = 1'b1;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            pc           <= RESET_PC;
            ir           <= '0;
            retired      <= '0;
            branch_taken <= 1'b0;
        end else begin
            if (state_q == S_FETCH && imem_ack) ir <= imem_data;
            if (state_q == S_EXECUTE) begin
                branch_taken <= ctrl.is_beqz & src_zero;
                if (ctrl.is_halt) retired <= retired + 16'd1;
            end
            if (state_q == S_WRITEBACK) begin
                retired <= retired + 16'd1;
                if (ctrl.is_jmp || branch_taken) pc <= target;
                else                             pc <= pc + PC_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer with hand-computed expectations.
// Drives instruction memory handshake directly from one linear sequence.
module tb_cpu_sequencer;

    logic        clk;
    logic        rstn;
    logic        run;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic        src_zero;
    logic [7:0]  pc;
    logic [15:0] ir;
    logic [2:0]  rf_raddr_a;
    logic [2:0]  rf_raddr_b;
    logic [2:0]  rf_waddr;
    logic        rf_we;
    logic [2:0]  alu_op;
    logic        mux1_sel;
    logic        mux2_sel;
    logic        halted;
    logic        illegal;
    logic [15:0] retired;

    int n_checks = 0;
    int n_fail   = 0;

    cpu_sequencer #(
        .PC_W     (8),
        .INSTR_W  (16),
        .RESET_PC (8'h00)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .run        (run),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_data  (imem_data),
        .src_zero   (src_zero),
        .pc         (pc),
        .ir         (ir),
        .rf_raddr_a (rf_raddr_a),
        .rf_raddr_b (rf_raddr_b),
        .rf_waddr   (rf_waddr),
        .rf_we      (rf_we),
        .alu_op     (alu_op),
        .mux1_sel   (mux1_sel),
        .mux2_sel   (mux2_sel),
        .halted     (halted),
        .illegal    (illegal),
        .retired    (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called in FETCH; returns one cycle after the ack, i.e. in DECODE.
    task automatic fetch(input logic [15:0] instr, input int waits,
                         input logic [7:0] addr);
        chk("fetch_req", 32'(imem_req), 32'd1);
        chk("fetch_addr", 32'(imem_addr), 32'(addr));
        for (int i = 0; i < waits; i++) begin
            tick();
            chk("wait_req", 32'(imem_req), 32'd1);
            chk("wait_addr", 32'(imem_addr), 32'(addr));
        end
        imem_ack  = 1'b1;
        imem_data = instr;
        tick();
        imem_ack  = 1'b0;
        imem_data = '0;
        chk("ir_load", 32'(ir), 32'(instr));
    endtask

    initial begin
        rstn      = 1'b1;
        run       = 1'b0;
        imem_ack  = 1'b0;
        imem_data = '0;
        src_zero  = 1'b0;
        repeat (2) tick();

        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_ir", 32'(ir), 32'h0);
        chk("rst_retired", 32'(retired), 32'h0);
        chk("rst_req", 32'(imem_req), 32'h0);
        chk("rst_we", 32'(rf_we), 32'h0);
        chk("rst_aluop", 32'(alu_op), 32'h0);
        chk("rst_sel", 32'({mux1_sel, mux2_sel}), 32'h0);
        chk("rst_flags", 32'({halted, illegal}), 32'h0);

        rstn = 1'b0;
        tick();
        chk("idle_no_run", 32'(imem_req), 32'h0);
        run = 1'b1;
        tick();

        // LDI r1,5
        fetch(16'h9205, 0, 8'h00);
        chk("ldi_dec_we", 32'(rf_we), 32'h0);
        tick();
        chk("ldi_ex_we", 32'(rf_we), 32'h0);
        tick();
        chk("ldi_wb_we", 32'(rf_we), 32'h1);
        chk("ldi_waddr", 32'(rf_waddr), 32'h1);
        chk("ldi_mux2", 32'(mux2_sel), 32'h1);
        chk("ldi_pc_wb", 32'(pc), 32'h0);
        tick();
        chk("ldi_pc", 32'(pc), 32'h1);
        chk("ldi_ret", 32'(retired), 32'h1);
        chk("ldi_we_off", 32'(rf_we), 32'h0);

        // ADD r1,r2,r3
        fetch(16'h1298, 0, 8'h01);
        chk("add_ra", 32'(rf_raddr_a), 32'h2);
        chk("add_rb", 32'(rf_raddr_b), 32'h3);
        tick();
        chk("add_aluop", 32'(alu_op), 32'h0);
        chk("add_mux1", 32'(mux1_sel), 32'h0);
        tick();
        chk("add_we", 32'(rf_we), 32'h1);
        chk("add_waddr", 32'(rf_waddr), 32'h1);
        chk("add_mux2", 32'(mux2_sel), 32'h0);
        tick();
        chk("add_pc", 32'(pc), 32'h2);

        // ADDI r1,r2,3
        fetch(16'h8283, 0, 8'h02);
        tick();
        chk("addi_mux1", 32'(mux1_sel), 32'h1);
        chk("addi_aluop", 32'(alu_op), 32'h0);
        tick();
        chk("addi_we", 32'(rf_we), 32'h1);
        tick();
        chk("addi_ret", 32'(retired), 32'h3);

        // XOR r1,r2,r3 -> alu_op 100
        fetch(16'h5298, 0, 8'h03);
        tick();
        chk("xor_aluop", 32'(alu_op), 32'h4);
        tick();
        tick();
        chk("xor_pc", 32'(pc), 32'h4);

        // BEQZ r2,0x10 taken
        fetch(16'hB410, 0, 8'h04);
        chk("beqz_ra", 32'(rf_raddr_a), 32'h2);
        src_zero = 1'b1;
        tick();
        tick();
        src_zero = 1'b0;
        chk("beqz_t_we", 32'(rf_we), 32'h0);
        tick();
        chk("beqz_t_pc", 32'(pc), 32'h10);
        chk("beqz_t_ret", 32'(retired), 32'h5);

        // BEQZ not taken
        fetch(16'hB410, 0, 8'h10);
        tick();
        tick();
        tick();
        chk("beqz_nt_pc", 32'(pc), 32'h11);

        // JMP 0xFF
        fetch(16'hA0FF, 0, 8'h11);
        tick();
        tick();
        chk("jmp_we", 32'(rf_we), 32'h0);
        tick();
        chk("jmp_pc", 32'(pc), 32'hFF);
        chk("jmp_ret", 32'(retired), 32'h7);

        // NOP at 0xFF with ack delayed 3 cycles: 7 cycles, pc wraps
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("dly_req", 32'(imem_req), 32'h1);
            chk("dly_addr", 32'(imem_addr), 32'hFF);
            chk("dly_ir", 32'(ir), 32'hA0FF);
        end
        imem_ack  = 1'b1;
        imem_data = 16'h0000;
        tick();
        imem_ack  = 1'b0;
        chk("dly_ir_ld", 32'(ir), 32'h0);
        tick();
        tick();
        chk("dly_wb_pc", 32'(pc), 32'hFF);
        chk("dly_wb_req", 32'(imem_req), 32'h0);
        tick();
        chk("dly_next_req", 32'(imem_req), 32'h1);
        chk("wrap_pc", 32'(pc), 32'h00);
        chk("dly_ret", 32'(retired), 32'h8);

        // Illegal 0xC000
        fetch(16'hC000, 0, 8'h00);
        chk("ill_dec", 32'(illegal), 32'h0);
        tick();
        chk("ill_ex", 32'(illegal), 32'h1);
        tick();
        chk("ill_wb", 32'(illegal), 32'h0);
        chk("ill_we", 32'(rf_we), 32'h0);
        tick();
        chk("ill_pc", 32'(pc), 32'h1);
        chk("ill_ret", 32'(retired), 32'h9);

        // run dropped during EXECUTE
        fetch(16'h9307, 0, 8'h01);
        tick();
        run = 1'b0;
        tick();
        chk("rg_we", 32'(rf_we), 32'h1);
        tick();
        chk("rg_idle_req", 32'(imem_req), 32'h0);
        chk("rg_pc", 32'(pc), 32'h2);
        chk("rg_ret", 32'(retired), 32'hA);
        tick();
        chk("rg_stay_idle", 32'(imem_req), 32'h0);
        run = 1'b1;
        tick();

        // HALT
        fetch(16'hF000, 0, 8'h02);
        tick();
        chk("halt_ex", 32'(halted), 32'h0);
        tick();
        chk("halt_flag", 32'(halted), 32'h1);
        chk("halt_pc", 32'(pc), 32'h2);
        chk("halt_ret", 32'(retired), 32'hB);
        chk("halt_req", 32'(imem_req), 32'h0);
        run = 1'b0;
        tick();
        run = 1'b1;
        tick();
        tick();
        chk("halt_hold", 32'(halted), 32'h1);
        chk("halt_pc_frz", 32'(pc), 32'h2);
        chk("halt_we", 32'(rf_we), 32'h0);

        // Asynchronous reset out of HALT
        #2;
        rstn = 1'b1;
        #1;
        chk("arst_pc", 32'(pc), 32'h0);
        chk("arst_halt", 32'(halted), 32'h0);
        chk("arst_ret", 32'(retired), 32'h0);

        // Asynchronous reset mid-FETCH with an ack pending
        tick();
        rstn = 1'b0;
        tick();
        chk("mf_req", 32'(imem_req), 32'h1);
        #2;
        rstn      = 1'b1;
        imem_ack  = 1'b1;
        imem_data = 16'h9205;
        #1;
        chk("mf_req_drop", 32'(imem_req), 32'h0);
        tick();
        rstn = 1'b0;
        run  = 1'b0;
        tick();
        chk("mf_ack_ign", 32'(ir), 32'h0);
        chk("mf_idle", 32'(imem_req), 32'h0);
        imem_ack = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Multi-cycle control sequencer for the 16-bit custom processor.
- Owns the program counter and the instruction register.
- Fetches over a req/ack handshake, decodes, and drives the datapath controls: ALU op, mux selects and register-file write.
- Sits between instruction memory and the existing register-file/MUX/ALU datapath, replacing hard-wired per-cycle control.

Parameters:
- PC_W, 8, program counter and instruction address width.
- INSTR_W, 16, instruction width; the decode field positions below are fixed for 16.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state on the rising edge.
- rstn  in  1  asynchronous, active-high reset. The name is kept for codebase consistency; 1 = reset.
- run  in  1  level; permits leaving IDLE.
- imem_req  out  1  fetch request.
- imem_addr  out  PC_W  fetch address; always equals pc.
- imem_ack  in  1  fetch complete; imem_data is valid in the same cycle.
- imem_data  in  INSTR_W  fetched instruction.
- src_zero  in  1  1 when register-file read port A == 0.
- pc  out  PC_W  current program counter.
- ir  out  INSTR_W  instruction register.
- rf_raddr_a  out  3  read address A = ir[8:6]; for BEQZ it is ir[11:9].
- rf_raddr_b  out  3  read address B = ir[5:3].
- rf_waddr  out  3  write address = ir[11:9].
- rf_we  out  1  register-file write strobe.
- alu_op  out  3  ALU operation: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 PASSB.
- mux1_sel  out  1  ALU B operand: 0 = reg B, 1 = zero-extended ir[5:0].
- mux2_sel  out  1  write-back source: 0 = ALU result, 1 = ir[7:0].
- halted  out  1  processor is in HALT.
- illegal  out  1  one-cycle pulse on an undefined opcode.
- retired  out  16  count of completed instructions.

Behaviour:
- Reset (async, rstn=1):
  - state=IDLE, pc=RESET_PC, ir=0, retired=0.
  - All strobes and selects are 0, and alu_op=000.
- Opcode = ir[15:12]:
  - 0x0 NOP.
  - 0x1–0x7: R-type, alu_op=opcode-1, rd=rs1 op rs2.
  - 0x8 ADDI: rd=rs1+imm6, mux1_sel=1, alu_op=000.
  - 0x9 LDI: rd=imm8, mux2_sel=1.
  - 0xA JMP imm8.
  - 0xB BEQZ rd,imm8: branch when reg[ir[11:9]]==0.
  - 0xF HALT.
  - 0xC–0xE: illegal; execute as NOP and pulse illegal in EXECUTE.
- FSM states: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT.
- IDLE: waits for run=1, then goes to FETCH.
- FETCH:
  - imem_req=1 and imem_addr=pc, both held stable until imem_ack.
  - On ack: ir<=imem_data, go to DECODE.
  - An ack arriving while req=0 is ignored.
- DECODE: one cycle; rf_raddr_a/b are valid.
- EXECUTE:
  - alu_op and mux1_sel are valid.
  - src_zero is sampled into branch_taken for BEQZ.
  - HALT opcode goes to HALT instead of WRITEBACK.
- WRITEBACK:
  - rf_we=1 for exactly one cycle, only for opcodes 0x1–0x9.
  - mux2_sel and rf_waddr are valid.
  - pc <= target (ir[7:0]) for JMP or taken BEQZ; otherwise pc+1.
  - pc wraps from 2^PC_W−1 to 0.
  - retired increments, wrapping at 0xFFFF.
  - Next state: FETCH if run=1, else IDLE.
- HALT:
  - halted=1 and all strobes 0; pc is not advanced.
  - retired counts the HALT instruction.
  - Only reset exits HALT.
- Latency: 4 cycles per instruction when imem_ack arrives in the first FETCH cycle; add one cycle per ack wait.
- Control outputs are registered per state and stable for the whole state.
- run deasserted mid-instruction: the current instruction completes, then the block enters IDLE.
- Reset during FETCH: imem_req drops immediately (async); an outstanding ack after reset is ignored.

Decomposition:
- Shared package `cpu_pkg`:
  - opcode constants;
  - ALU op encodings;
  - state encoding;
  - instruction field positions (RD_HI/LO, RS1, RS2, IMM6, IMM8).
- One natural sub-module, `cpu_decoder`: combinational ir → {alu_op, mux1_sel, mux2_sel, writes_rf, is_jmp, is_beqz, is_halt, is_illegal}.
- The FSM, pc and counters stay in `cpu_sequencer`.

Test Plan:
- Reset then run=1, memory acks immediately, program 0x9205 (LDI r1,5):
  - rf_we pulses in cycle 4, rf_waddr=1, mux2_sel=1;
  - pc 0→1, retired=1.
- R-type 0x1298 (ADD r1,r2,r3):
  - alu_op=000, rf_raddr_a=2, rf_raddr_b=3, mux1_sel=0, rf_waddr=1.
  - ADDI 0x8283 gives mux1_sel=1, alu_op=000.
- Branches:
  - BEQZ 0xB410 with src_zero=1 → pc=0x10, rf_we stays 0.
  - Same instruction with src_zero=0 → pc+1.
  - JMP 0xA0FF → pc=0xFF; the next sequential instruction wraps pc to 0x00.
- imem_ack delayed 3 cycles:
  - imem_req held with a constant imem_addr;
  - ir loads only on the ack cycle;
  - the instruction takes 7 cycles.
- Error and stop cases:
  - 0xC000 → one-cycle illegal pulse, no rf_we, pc+1.
  - 0xF000 → halted=1; pc frozen; run toggling has no effect; rstn=1 clears to pc=0.
- Asynchronous reset and run gating:
  - rstn=1 asserted mid-FETCH → imem_req and state clear without waiting for a clock edge.
  - run=0 during EXECUTE → the instruction retires, then the block enters IDLE with imem_req=0.
